controle: RTL and testbench
===========================

CONTROLE -- requirements
Module: controle

Interface
REQ-001 The block SHALL have no parameters; all encodings are fixed by this document.
REQ-002 Port `ck`, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 Port `rst`, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port `start`, input, 1 bit: requests one evaluation; sampled only in IDLE.
REQ-005 Port `op`, input, 2 bits: polynomial select, captured when start is accepted.
REQ-006 Port `ack`, input, 1 bit: result-consumed acknowledge; used only when CONTROLE_DONE_HOLD_EN is defined.
REQ-007 Port `lx`, output, 1 bit: load X register in the datapath.
REQ-008 Port `m0`, output, 2 bits: constant select (00 zero, 01 A, 10 B, 11 C).
REQ-009 Port `m1`, output, 2 bits: operand-1 select (00 constant, 01 X, 10 S, 11 H).
REQ-010 Port `m2`, output, 2 bits: operand-2 select (00 X, 01 constant, 10 S, 11 H).
REQ-011 Port `h`, output, 1 bit: 0 selects add, 1 selects multiply.
REQ-012 Ports `ls` and `lh`, output, 1 bit each: load S, load H.
REQ-013 Port `done`, output, 1 bit: result valid on the datapath Resultado.
REQ-014 Port `busy`, output, 1 bit: high in every state except IDLE.

Function
REQ-015 The block SHALL be a Moore FSM: all outputs decode from the state register only; outputs not listed for a state are 0.
REQ-016 The states SHALL be:
- IDLE: no outputs asserted.
- LX: lx=1.
- P1: m1=00, m0=01, m2=00, h=1, ls=1 (S=A*X).
- P2: m1=10, m2=01, m0=10, h=0, ls=1 (S=S+B).
- P3: m1=10, m2=00, h=1, ls=1 (S=S*X).
- P4: m1=10, m2=01, m0=11, h=0, ls=1 (S=S+C).
- DONE: done=1.
REQ-017 In IDLE with start=1 at a rising edge, the block SHALL capture op into an internal register and go to LX; start=0 keeps IDLE.
REQ-018 Sequences SHALL be:
- op=00 (A*X+B): LX,P1,P2,DONE.
- op=01 or 11 (A*X^2+B*X+C): LX,P1,P2,P3,P4,DONE.
- op=10 (A*X^2+C): LX,P1,P3,P4,DONE.
REQ-019 Every non-IDLE, non-DONE state SHALL last exactly one cycle; done SHALL first assert 4/6/5 cycles (op 00/01/10) after the accepting edge.
REQ-020 start, and changes to op, SHALL be ignored while busy=1.
REQ-021 The block SHALL never assert ls and lh together, and SHALL never assert lh (reserved for future sequences).
REQ-022 Arithmetic width, overflow and truncation are owned by the datapath; the controller performs no arithmetic.

Reset
REQ-023 With rst=1, the state SHALL go to IDLE immediately, independent of ck, including mid-sequence.
REQ-024 During reset, the captured op register SHALL be 00 and every output SHALL be 0, including busy and done.
REQ-025 The block SHALL accept start on the first rising edge after rst is released.

Configuration
REQ-026 Macro CONTROLE_DONE_HOLD_EN:
- Defined: DONE SHALL persist until a rising edge with ack=1, then go to IDLE.
- Undefined: DONE SHALL last exactly one cycle, and ack SHALL be ignored.

Verification
REQ-027 op=01, A=2, B=3, C=4, X=5, start pulsed 1 cycle -> done after 6 cycles, Resultado=69, with the exact state-by-state control vector.
REQ-028 op=00, same operands -> done after 4 cycles, Resultado=13; op=10 -> done after 5 cycles, Resultado=54.
REQ-029 op=01 started, then start held high and op changed to 00 mid-sequence -> sequence unaffected, Resultado=69, single accept only.
REQ-030 rst asserted in P2 between clock edges -> outputs 0 and busy=0 without a clock edge; next start with op=00 yields 13.
REQ-031 With macro defined: ack held 0 for 10 cycles -> done stays 1; ack=1 -> IDLE next edge. Without macro: done high exactly 1 cycle.

Source files
------------

// File: rtl/controle_if.sv
// Bus between the CONTROLE polynomial sequencer and its datapath/host.
// The slave modport is the controller side; the master side drives start/op/ack.
interface controle_if;
    // Handshake: start is a request that is taken only on a rising edge while
    // busy=0, and op is captured on that same edge. done marks a valid result.
    // With CONTROLE_DONE_HOLD_EN, done holds until an edge with ack=1.
    logic       start;
    logic [1:0] op;
    logic       ack;
    logic       lx;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       h;
    logic       ls;
    logic       lh;
    logic       done;
    logic       busy;
    logic [2:0] dbg_state;
    logic [1:0] dbg_op;

    modport master (
        output start, op, ack,
        input  lx, m0, m1, m2, h, ls, lh, done, busy, dbg_state, dbg_op
    );

    modport slave (
        input  start, op, ack,
        output lx, m0, m1, m2, h, ls, lh, done, busy, dbg_state, dbg_op
    );
endinterface

// File: rtl/controle.sv
// Moore sequencer for A*X+B, A*X^2+B*X+C and A*X^2+C on a shared add/mul datapath.
// Build option CONTROLE_DONE_HOLD_EN: DONE holds until ack instead of lasting one cycle.
module controle (
    input  logic      ck,
    input  logic      rst,
    controle_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LX   = 3'd1;
    localparam logic [2:0] S_P1   = 3'd2;
    localparam logic [2:0] S_P2   = 3'd3;
    localparam logic [2:0] S_P3   = 3'd4;
    localparam logic [2:0] S_P4   = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0] state_q, state_d;
    logic [1:0] op_q, op_d;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // op 00 skips P3/P4, op 10 skips P2; op 11 behaves like op 01.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LX;
                    op_d    = bus.op;
                end
            end
            S_LX:   state_d = S_P1;
            S_P1:   state_d = (op_q == 2'b10) ? S_P3 : S_P2;
            S_P2:   state_d = (op_q == 2'b00) ? S_DONE : S_P3;
            S_P3:   state_d = S_P4;
            S_P4:   state_d = S_DONE;
`ifdef CONTROLE_DONE_HOLD_EN
            S_DONE: state_d = bus.ack ? S_IDLE : S_DONE;
`else
            S_DONE: state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.lx   = 1'b0;
        bus.m0   = 2'b00;
        bus.m1   = 2'b00;
        bus.m2   = 2'b00;
        bus.h    = 1'b0;
        bus.ls   = 1'b0;
        bus.lh   = 1'b0;
        bus.done = 1'b0;
        bus.busy = (state_q != S_IDLE);
        case (state_q)
            S_LX: bus.lx = 1'b1;
            S_P1: begin
                bus.m0 = 2'b01;
                bus.h  = 1'b1;
                bus.ls = 1'b1;
            end
            S_P2: begin
                bus.m1 = 2'b10;
                bus.m2 = 2'b01;
                bus.m0 = 2'b10;
                bus.ls = 1'b1;
            end
            S_P3: begin
                bus.m1 = 2'b10;
                bus.h  = 1'b1;
                bus.ls = 1'b1;
            end
            S_P4: begin
                bus.m1 = 2'b10;
                bus.m2 = 2'b01;
                bus.m0 = 2'b11;
                bus.ls = 1'b1;
            end
            S_DONE: bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.dbg_state = state_q;
    assign bus.dbg_op    = op_q;
endmodule

// File: tb/tb_controle.sv
// Directed bench for controle with a small datapath model that turns the
// control vector into Resultado for A=2, B=3, C=4, X=5.
module tb_controle;
    logic ck;
    logic rst;
    int   checks;
    int   failures;

    controle_if bus_if ();

    controle dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus_if)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Vector order: lx, m0, m1, m2, h, ls, lh, done, busy
    localparam logic [11:0] V_IDLE = 12'b0_00_00_00_0_0_0_0_0;
    localparam logic [11:0] V_LX   = 12'b1_00_00_00_0_0_0_0_1;
    localparam logic [11:0] V_P1   = 12'b0_01_00_00_1_1_0_0_1;
    localparam logic [11:0] V_P2   = 12'b0_10_10_01_0_1_0_0_1;
    localparam logic [11:0] V_P3   = 12'b0_00_10_00_1_1_0_0_1;
    localparam logic [11:0] V_P4   = 12'b0_11_10_01_0_1_0_0_1;
    localparam logic [11:0] V_DN   = 12'b0_00_00_00_0_0_0_1_1;

    logic [11:0] cvec;
    assign cvec = {bus_if.lx, bus_if.m0, bus_if.m1, bus_if.m2, bus_if.h,
                   bus_if.ls, bus_if.lh, bus_if.done, bus_if.busy};

    // Datapath model: X and S registers, constants A/B/C, H never loaded.
    localparam logic [15:0] K_A = 16'd2;
    localparam logic [15:0] K_B = 16'd3;
    localparam logic [15:0] K_C = 16'd4;
    localparam logic [15:0] X_IN = 16'd5;
    logic [15:0] xr;
    logic [15:0] sr;
    logic [15:0] hr;

    function automatic logic [15:0] kconst(input logic [1:0] sel);
        case (sel)
            2'b01:   return K_A;
            2'b10:   return K_B;
            2'b11:   return K_C;
            default: return 16'd0;
        endcase
    endfunction

    always @(posedge ck) begin
        logic [15:0] k, a1, a2;
        k = kconst(bus_if.m0);
        case (bus_if.m1)
            2'b00:   a1 = k;
            2'b01:   a1 = xr;
            2'b10:   a1 = sr;
            default: a1 = hr;
        endcase
        case (bus_if.m2)
            2'b00:   a2 = xr;
            2'b01:   a2 = k;
            2'b10:   a2 = sr;
            default: a2 = hr;
        endcase
        if (bus_if.lx) xr <= X_IN;
        if (bus_if.ls) sr <= bus_if.h ? a1 * a2 : a1 + a2;
        if (bus_if.lh) hr <= bus_if.h ? a1 * a2 : a1 + a2;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge in IDLE; checks every cycle's control vector,
    // Resultado in DONE, and the return to IDLE.
    task automatic run_seq(input logic [1:0] op_v, input int n, input logic [11:0] ev [6],
                           input logic [15:0] exp_res, input string tag, input bit meddle);
        bus_if.start = 1'b1;
        bus_if.op    = op_v;
        @(negedge ck);
        if (meddle) bus_if.op = 2'b00;
        else        bus_if.start = 1'b0;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_vec%0d", tag, k), {4'b0, cvec}, {4'b0, ev[k]});
            if (k == n - 1) begin
                chk($sformatf("%s_result", tag), sr, exp_res);
                bus_if.start = 1'b0;
            end
            @(negedge ck);
        end
`ifdef CONTROLE_DONE_HOLD_EN
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("%s_hold%0d", tag, k), {4'b0, cvec}, {4'b0, V_DN});
            @(negedge ck);
        end
        bus_if.ack = 1'b1;
        @(negedge ck);
        bus_if.ack = 1'b0;
`endif
        chk($sformatf("%s_idle_after", tag), {4'b0, cvec}, {4'b0, V_IDLE});
        @(negedge ck);
        chk($sformatf("%s_idle_after2", tag), {4'b0, cvec}, {4'b0, V_IDLE});
    endtask

    logic [11:0] seq01 [6];
    logic [11:0] seq00 [6];
    logic [11:0] seq10 [6];

    initial begin
        checks        = 0;
        failures      = 0;
        xr            = 16'd0;
        sr            = 16'd0;
        hr            = 16'd0;
        seq01         = '{V_LX, V_P1, V_P2, V_P3, V_P4, V_DN};
        seq00         = '{V_LX, V_P1, V_P2, V_DN, V_IDLE, V_IDLE};
        seq10         = '{V_LX, V_P1, V_P3, V_P4, V_DN, V_IDLE};
        rst           = 1'b1;
        bus_if.start  = 1'b0;
        bus_if.op     = 2'b11;
        bus_if.ack    = 1'b0;

        #1;
        chk("reset_vec", {4'b0, cvec}, {4'b0, V_IDLE});
        chk("reset_op", {14'b0, bus_if.dbg_op}, 16'd0);
        bus_if.start = 1'b1;
        @(negedge ck);
        chk("reset_held_vec", {4'b0, cvec}, {4'b0, V_IDLE});
        rst          = 1'b0;
        bus_if.start = 1'b0;
        @(negedge ck);
        chk("idle_no_start", {4'b0, cvec}, {4'b0, V_IDLE});
        @(negedge ck);
        chk("idle_no_start2", {4'b0, cvec}, {4'b0, V_IDLE});

        run_seq(2'b01, 6, seq01, 16'd69, "op01", 1'b0);
        run_seq(2'b00, 4, seq00, 16'd13, "op00", 1'b0);
        run_seq(2'b10, 5, seq10, 16'd54, "op10", 1'b0);
        run_seq(2'b11, 6, seq01, 16'd69, "op11", 1'b0);
        run_seq(2'b01, 6, seq01, 16'd69, "op01_meddle", 1'b1);

        // Reset asserted between edges while in P2.
        bus_if.start = 1'b1;
        bus_if.op    = 2'b01;
        @(negedge ck);
        bus_if.start = 1'b0;
        chk("rst_seq_lx", {4'b0, cvec}, {4'b0, V_LX});
        @(negedge ck);
        chk("rst_seq_p1", {4'b0, cvec}, {4'b0, V_P1});
        @(negedge ck);
        chk("rst_seq_p2", {4'b0, cvec}, {4'b0, V_P2});
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_vec", {4'b0, cvec}, {4'b0, V_IDLE});
        chk("rst_async_busy", {15'b0, bus_if.busy}, 16'd0);
        chk("rst_async_op", {14'b0, bus_if.dbg_op}, 16'd0);
        @(negedge ck);
        chk("rst_hold_vec", {4'b0, cvec}, {4'b0, V_IDLE});
        rst = 1'b0;
        run_seq(2'b00, 4, seq00, 16'd13, "after_rst_op00", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
